// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the fetch PC, runs a req/ack handshake to
// instruction memory and buffers up to two fetched words for decode.
//
// state | meaning
// IDLE  | no request outstanding (buffer full, or just out of reset)
// REQ   | request to req_addr outstanding, its data will be kept
// DROP  | request outstanding but stale after a flush, its data is discarded
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        id_stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_n;
  logic        push, pop;
  logic [31:0] new_pc_al;

  assign new_pc_al    = new_pc_i & ~32'h3;
  assign imem_req_o   = (state == REQ) || (state == DROP);
  assign imem_addr_o  = req_addr;
  assign inst_valid_o = (count != 2'd0);
  assign pc_o         = inst_valid_o ? fifo_pc[rd_ptr]   : 32'h0;
  assign inst_o       = inst_valid_o ? fifo_inst[rd_ptr] : 32'h0;

  // A flush clears the buffer outright, so neither push nor pop may happen with it
  assign push    = (state == REQ) && imem_ack_i && !flush_i;
  assign pop     = inst_valid_o && !id_stall_i && !flush_i;
  assign count_n = count + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_addr_n = req_addr;
    if (flush_i) begin
      fetch_pc_n = new_pc_al;
      if (state != IDLE && !imem_ack_i) begin
        state_n = DROP;
      end else begin
        state_n    = REQ;
        req_addr_n = new_pc_al;
      end
    end else begin
      case (state)
        IDLE: begin
          if (count_n < 2'd2) begin
            state_n    = REQ;
            req_addr_n = fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack_i) begin
            fetch_pc_n = req_addr + 32'd4;
            if (count_n < 2'd2) req_addr_n = req_addr + 32'd4;
            else                state_n    = IDLE;
          end
        end
        DROP: begin
          if (imem_ack_i) begin
            state_n    = REQ;
            req_addr_n = fetch_pc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC & ~32'h3;
      req_addr <= 32'h0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_addr <= req_addr_n;
      if (flush_i) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        count <= count_n;
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= req_addr;
      fifo_inst[wr_ptr] <= imem_data_i;
    end
  end

endmodule
